// File: rtl/binary_tile_streamer.sv
// Buffers 64-bit binary tiles in a FIFO and streams each out as four 16-bit words over valid/ready.
// Optional TILE_POPCOUNT_EN macro: store and present a per-tile count of 1-pixels on ones_o.
module binary_tile_streamer #(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tile_valid_i,
    input  logic [15:0]      pack0_i,
    input  logic [15:0]      pack1_i,
    input  logic [15:0]      pack2_i,
    input  logic [15:0]      pack3_i,
    output logic [15:0]      word_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic             word_last_o,
    output logic [6:0]       ones_o,
    output logic [LVL_W-1:0] level_o,
    output logic             overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [1:0]       idx_q, idx_d;
    logic             ovf_q, ovf_d;

    logic [63:0] mem_q [DEPTH];
    logic [63:0] tile_w;
    logic [63:0] head_w;
    logic        full, xfer, pop, push, drop;

    assign tile_w = {pack0_i, pack1_i, pack2_i, pack3_i};
    assign head_w = mem_q[rd_ptr_q];

    assign word_valid_o = (level_q != '0);
    assign full         = (level_q == LVL_W'(DEPTH));
    assign xfer         = word_valid_o && word_ready_i;
    assign pop          = xfer && (idx_q == 2'd3);
    // A full FIFO still accepts a tile when the head tile leaves on the same edge.
    assign push         = tile_valid_i && (!full || pop);
    assign drop         = tile_valid_i && full && !pop;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (xfer) idx_d = idx_q + 2'd1;
        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (pop && !push) level_d = level_q - LVL_W'(1);
        if (drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: tile storage is not reset; level_q == 0 already hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tile_w;
    end

    assign word_o      = word_valid_o ? head_w[{idx_q, 4'b0000} +: 16] : 16'h0000;
    assign word_last_o = word_valid_o && (idx_q == 2'd3);
    assign level_o     = level_q;
    assign overflow_o  = ovf_q;

`ifdef TILE_POPCOUNT_EN
    logic [6:0] cnt_mem_q [DEPTH];
    logic [6:0] tile_ones;

    always_comb begin
        tile_ones = '0;
        for (int i = 0; i < 64; i++) tile_ones = tile_ones + {6'd0, tile_w[i]};
    end

    always_ff @(posedge clk) begin
        if (push) cnt_mem_q[wr_ptr_q] <= tile_ones;
    end

    assign ones_o = word_valid_o ? cnt_mem_q[rd_ptr_q] : 7'd0;
`else
    assign ones_o = 7'd0;
`endif

endmodule
